// File: rtl/key_schedule.sv
// key_schedule: iterates a 16-bit round key ROUNDS times from a master key.
// Each step rotates left by 5, substitutes the top nibble through a 4-bit
// S-box and mixes the round index into the low nibble. Keys are handed to the
// downstream key-addition stage with a valid/ready handshake.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   io_start     in   start a new schedule (accepted only in IDLE)
//   io_key       in   16-bit master key, captured with io_start
//   io_ready     in   downstream accepts the current round key
//   io_roundKey  out  current round key (key register)
//   io_round     out  index of the key on io_roundKey
//   io_valid     out  io_roundKey/io_round valid
//   io_done      out  final round key is being presented
//   io_busy      out  schedule in progress
module key_schedule #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [15:0] io_key,
  input  logic        io_ready,
  output logic [15:0] io_roundKey,
  output logic [3:0]  io_round,
  output logic        io_valid,
  output logic        io_done,
  output logic        io_busy
);

  localparam int unsigned KW = 16;
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [KW-1:0] key_q;
  logic [KW-1:0] key_d;
  logic [RW-1:0] round_q;
  logic [RW-1:0] round_d;
  logic          run;
  logic          last;
  logic          xfer;

  // 4-bit substitution box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-update step: rotl 5, S-box on top nibble, round index into low nibble
  function automatic logic [KW-1:0] next_key(input logic [KW-1:0] k,
                                             input logic [RW-1:0] r);
    logic [KW-1:0] t;
    t        = {k[KW-6:0], k[KW-1:KW-5]};
    t[15:12] = sbox(t[15:12]);
    t[3:0]   = t[3:0] ^ r;
    return t;
  endfunction

  assign run  = (state_q == RUN);
  assign last = (round_q == LAST_ROUND);
  assign xfer = run & io_ready;

  // Candidate next round index and key, used only on a non-final transfer
  always_comb begin
    round_d = RW'(round_q + RW'(1));
    key_d   = next_key(key_q, round_d);
  end

  // Schedule FSM; key and round hold unless loaded or advanced
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_start) begin
            state_q <= RUN;
            key_q   <= io_key;
            round_q <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              state_q <= IDLE;
            end else begin
              key_q   <= key_d;
              round_q <= round_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only
  assign io_roundKey = key_q;
  assign io_round    = round_q;
  assign io_valid    = run;
  assign io_busy     = run;
  assign io_done     = run & last;

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: table of master keys with hand-derived early round
// keys, a model-fed scoreboard checking every presented key, plus stall,
// start-during-run, mid-run reset and ROUNDS=1 sequences.
module tb_key_schedule;

  localparam int unsigned ROUNDS = 10;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic [15:0] io_key;
  logic        io_ready;
  logic [15:0] io_roundKey;
  logic [3:0]  io_round;
  logic        io_valid;
  logic        io_done;
  logic        io_busy;

  logic        start1;
  logic [15:0] key1;
  logic        ready1;
  logic [15:0] rkey1;
  logic [3:0]  round1;
  logic        valid1;
  logic        done1;
  logic        busy1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic [15:0] key;
    logic [3:0]  round;
    logic        done;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] key;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
  } vec_t;

  key_schedule #(.ROUNDS(ROUNDS)) dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_key(io_key),
    .io_ready(io_ready), .io_roundKey(io_roundKey), .io_round(io_round),
    .io_valid(io_valid), .io_done(io_done), .io_busy(io_busy)
  );

  key_schedule #(.ROUNDS(1)) dut1 (
    .clock(clock), .reset(reset), .io_start(start1), .io_key(key1),
    .io_ready(ready1), .io_roundKey(rkey1), .io_round(round1),
    .io_valid(valid1), .io_done(done1), .io_busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model of the key update
  function automatic logic [15:0] model_f(input logic [15:0] k, input int r);
    logic [3:0]  sb_tab [16];
    logic [15:0] t;
    sb_tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    t = 16'((k << 5) | (k >> 11));
    t = {sb_tab[t[15:12]], t[11:0]};
    t = t ^ 16'(r & 15);
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every presented key, retire it on transfer
  always @(negedge clock) begin
    if (mon_en && io_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got round %0d key %h with nothing expected", io_round, io_roundKey);
      end else begin
        check("sb_key", io_roundKey, sb[0].key);
        check("sb_round", 16'(io_round), 16'(sb[0].round));
        check("sb_done", 16'(io_done), 16'(sb[0].done));
        if (io_ready) void'(sb.pop_front());
      end
    end
  end

  // Pulse io_start from IDLE and queue the whole expected schedule
  task automatic start_run(input logic [15:0] key);
    logic [15:0] k;
    @(posedge clock); #1;
    io_start = 1'b1;
    io_key   = key;
    k = key;
    for (int r = 0; r <= int'(ROUNDS); r++) begin
      sb.push_back('{key: k, round: 4'(r), done: (r == int'(ROUNDS))});
      k = model_f(k, r + 1);
    end
    @(posedge clock); #1;
    io_start = 1'b0;
    io_key   = 16'($urandom);
  endtask

  // Bounded wait for the final transfer; records early keys and valid count
  task automatic wait_done(output int nv, output logic [15:0] k0, output logic [15:0] k1,
                           output logic [15:0] k2, output logic first_v);
    bit timeout;
    nv = 0; k0 = '0; k1 = '0; k2 = '0; first_v = 1'b0; timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (c == 0) first_v = io_valid;
      if (io_valid) begin
        nv++;
        if (io_ready) begin
          if (io_round == 4'd0) k0 = io_roundKey;
          if (io_round == 4'd1) k1 = io_roundKey;
          if (io_round == 4'd2) k2 = io_roundKey;
          if (io_done) begin
            timeout = 1'b0;
            break;
          end
        end
      end
    end
    if (timeout) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done transfer within 200 cycles");
    end
  endtask

  task automatic check_idle_next(input string name);
    @(posedge clock); #1;
    io_start = 1'b0;
    @(negedge clock);
    check({name, "_busy"}, 16'(io_busy), 16'd0);
    check({name, "_valid"}, 16'(io_valid), 16'd0);
  endtask

  initial begin
    vec_t        vecs [3];
    int          nv;
    logic [15:0] k0, k1, k2;
    logic        fv;
    bit          seen;
    int          cnt;
    logic [3:0]  dround;
    logic [15:0] dkey;

    vecs[0] = '{key: 16'h0000, r0: 16'h0000, r1: 16'hC001, r2: 16'hC03A};
    vecs[1] = '{key: 16'hFFFF, r0: 16'hFFFF, r1: 16'h2FFE, r2: 16'h2FC7};
    vecs[2] = '{key: 16'h1234, r0: 16'h1234, r1: 16'h9683, r2: 16'h7070};

    // Reset with io_start also high: reset must win
    reset = 1'b1; io_start = 1'b1; io_key = 16'hBEEF; io_ready = 1'b1;
    start1 = 1'b0; key1 = 16'h0000; ready1 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; io_start = 1'b0;
    @(negedge clock);
    check("rst_key", io_roundKey, 16'h0000);
    check("rst_round", 16'(io_round), 16'd0);
    check("rst_valid", 16'(io_valid), 16'd0);
    check("rst_done", 16'(io_done), 16'd0);
    check("rst_busy", 16'(io_busy), 16'd0);
    mon_en = 1'b1;

    // Table-driven full schedules with io_ready held high
    for (int i = 0; i < 3; i++) begin
      start_run(vecs[i].key);
      wait_done(nv, k0, k1, k2, fv);
      check("vec_first_valid", 16'(fv), 16'd1);
      check("vec_nvalid", 16'(nv), 16'(ROUNDS + 1));
      check("vec_r0", k0, vecs[i].r0);
      check("vec_r1", k1, vecs[i].r1);
      check("vec_r2", k2, vecs[i].r2);
      check_idle_next("vec_after");
    end

    // Stall three cycles at round 1
    start_run(16'h0000);
    @(posedge clock); #1;
    io_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check("stall_key", io_roundKey, 16'hC001);
      check("stall_round", 16'(io_round), 16'd1);
    end
    @(posedge clock); #1;
    io_ready = 1'b1;
    wait_done(nv, k0, k1, k2, fv);
    check("stall_r2", k2, 16'hC03A);
    check_idle_next("stall_after");

    // io_start held high with a different key throughout the run and done cycle
    start_run(16'h0000);
    io_start = 1'b1;
    io_key   = 16'h1234;
    wait_done(nv, k0, k1, k2, fv);
    check("ign_nvalid", 16'(nv), 16'(ROUNDS + 1));
    check("ign_r1", k1, 16'hC001);
    check_idle_next("ign_after");

    // Reset mid-run at round 5, then a fresh schedule
    start_run(16'hFFFF);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (io_valid && io_round == 4'd5) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_reach_r5", 16'(seen), 16'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    check("mid_rst_valid", 16'(io_valid), 16'd0);
    check("mid_rst_key", io_roundKey, 16'h0000);
    check("mid_rst_round", 16'(io_round), 16'd0);
    start_run(16'h1234);
    wait_done(nv, k0, k1, k2, fv);
    check("mid_fresh_r1", k1, 16'h9683);
    check("mid_fresh_nvalid", 16'(nv), 16'(ROUNDS + 1));
    check_idle_next("mid_after");

    // ROUNDS=1 instance: two valid cycles, done with round 1
    @(posedge clock); #1;
    start1 = 1'b1;
    key1   = 16'h0000;
    @(posedge clock); #1;
    start1 = 1'b0;
    key1   = 16'hAAAA;
    cnt = 0; seen = 1'b0; dround = '0; dkey = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (valid1) cnt++;
      if (valid1 && done1) begin
        seen   = 1'b1;
        dround = round1;
        dkey   = rkey1;
        break;
      end
    end
    check("r1_done_seen", 16'(seen), 16'd1);
    check("r1_nvalid", 16'(cnt), 16'd2);
    check("r1_done_round", 16'(dround), 16'd1);
    check("r1_done_key", dkey, 16'hC001);
    @(negedge clock);
    check("r1_idle_busy", 16'(busy1), 16'd0);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have parameter ROUNDS, default 10: number of round-key updates after the master key; legal range 1..15.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port io_start  input  1  request a new key schedule; sampled only in IDLE.
REQ-005 SHALL have port io_key  input  16  master key; sampled in the cycle io_start is accepted.
REQ-006 SHALL have port io_ready  input  1  downstream (key-addition stage) accepts the current round key.
REQ-007 SHALL have port io_roundKey  output  16  current round key, driven directly from the key register; feeds the key-addition io_key input.
REQ-008 SHALL have port io_round  output  4  index of the round key on io_roundKey.
REQ-009 SHALL have port io_valid  output  1  io_roundKey/io_round valid.
REQ-010 SHALL have port io_done  output  1  high with the final round key (io_round == ROUNDS).
REQ-011 SHALL have port io_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE and RUN only.
REQ-013 IDLE: io_valid=0, io_done=0, io_busy=0; key register and round counter hold their values.
REQ-014 IDLE & io_start=1 -> next cycle RUN, key register <= io_key, round counter <= 0.
REQ-015 RUN: io_valid=1, io_busy=1; io_round = round counter.
REQ-016 Transfer occurs in a cycle with io_valid & io_ready; without a transfer, key register and round counter SHALL hold (stall, any length).
REQ-017 On transfer with round < ROUNDS: key <= F(key, round+1), round <= round+1; state stays RUN.
REQ-018 io_done = RUN & (round == ROUNDS); on transfer in that cycle state -> IDLE; key register and round counter hold.
REQ-019 F(k, r): t = k rotated left by 5 bits (16-bit rotate); t[15:12] <= S(t[15:12]); t[3:0] <= t[3:0] XOR r[3:0]; result = t.
REQ-020 S (4-bit, hex, input 0..F): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
REQ-021 io_start SHALL be ignored in RUN, including the io_done cycle; no restart or reload.
REQ-022 With io_ready held 1: start accepted at cycle t -> round 0 at t+1, round ROUNDS with io_done at t+1+ROUNDS, IDLE at t+2+ROUNDS (next start accepted there).
REQ-023 io_key changes outside the accept cycle SHALL have no effect.
REQ-024 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to any output.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, key register=0x0000, round counter=0, regardless of state (including mid-RUN or stall).
REQ-026 In the cycle after reset: io_roundKey=0x0000, io_round=0, io_valid=0, io_done=0, io_busy=0.
REQ-027 reset SHALL take priority over io_start in the same cycle.

Verification
REQ-028 io_key=0x0000, io_start pulse, io_ready=1 -> keys 0x0000 (r0), 0xC001 (r1), 0xC03A (r2), ...; io_done only with r10; io_busy low the cycle after.
REQ-029 io_key=0xFFFF, io_start, io_ready=1 -> r0=0xFFFF, r1=0x2FFE; 11 valid cycles total.
REQ-030 io_ready=0 for 3 cycles at r1 -> io_roundKey=0xC001, io_round=1 held stable all 3 cycles; r2=0xC03A after io_ready returns to 1.
REQ-031 io_start=1 with io_key=0x1234 during RUN and in the io_done cycle -> sequence unchanged; new run begins only from IDLE.
REQ-032 reset asserted at r5 -> next cycle io_valid=0, io_roundKey=0x0000, io_round=0; a following start produces a correct fresh sequence.
REQ-033 ROUNDS=1 -> exactly two valid cycles (r0, r1), io_done with r1.
